// File: rtl/apb4_slave_regfile.sv
// apb4_slave_regfile: APB4 slave with NUM_REGS byte-strobed registers, programmable wait states
// and PSLVERR on misaligned, out-of-range, strobed-read or non-secure access to register 0.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb4_slave_regfile #(
    parameter int ADDR_WIDTH  = `APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = `APB_DATA_WIDTH,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    localparam int IW = $clog2(NUM_REGS);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         strb_q, strb_d;
    logic                  write_q, write_d;
    logic                  nsec_q, nsec_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [IW-1:0]         idx;
    logic                  err, setup, commit;
    logic                  unused_prot;

    assign unused_prot = ^{PPROT[2], PPROT[0]};
    assign idx    = addr_q[IW+1:2];
    assign err    = (addr_q[1:0] != 2'b00) || (addr_q[ADDR_WIDTH-1:IW+2] != '0) ||
                    (!write_q && strb_q != '0) || (nsec_q && idx == '0);
    assign setup  = (state_q != ACCESS) && PSEL && !PENABLE;
    assign commit = (state_q == ACCESS) && PSEL && PENABLE && pready_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        write_d  = write_q;
        nsec_d   = nsec_q;
        cnt_d    = cnt_q;
        pready_d = pready_q;
        if (setup) begin
            state_d  = ACCESS;
            addr_d   = PADDR;
            wdata_d  = PWDATA;
            strb_d   = PSTRB;
            write_d  = PWRITE;
            nsec_d   = PPROT[1];
            cnt_d    = 4'(WAIT_CYCLES);
            pready_d = (WAIT_CYCLES == 0);
        end else if (state_q == ACCESS) begin
            // an abandoned transfer leaves no trace: back to IDLE, nothing committed
            if (!PSEL) begin
                state_d  = IDLE;
                cnt_d    = '0;
                pready_d = 1'b0;
            end else if (commit) begin
                state_d  = DONE;
                pready_d = 1'b0;
            end else if (PENABLE && cnt_q != '0) begin
                cnt_d    = cnt_q - 4'd1;
                pready_d = (cnt_q == 4'd1);
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            write_q  <= 1'b0;
            nsec_q   <= 1'b0;
            cnt_q    <= '0;
            pready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            write_q  <= write_d;
            nsec_q   <= nsec_d;
            cnt_q    <= cnt_d;
            pready_q <= pready_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (commit && write_q && !err) begin
            for (int b = 0; b < SW; b++)
                if (strb_q[b]) regs_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end

    // read data is taken from the register array in the completing cycle itself
    assign PREADY  = pready_q;
    assign PSLVERR = pready_q && err;
    assign PRDATA  = (pready_q && !err && !write_q) ? regs_q[idx] : '0;
endmodule

// File: tb/tb_apb4_slave_regfile.sv
// tb_apb4_slave_regfile: vector table, directed corner sequences and random traffic against
// an array-based model, on one WAIT_CYCLES=1 and one WAIT_CYCLES=0 instance.
`timescale 1ns/1ps
module tb_apb4_slave_regfile;
    logic        PCLK = 1'b0;
    logic        rstn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    bit          which;
    logic [31:0] prdata0, prdata1, prdata;
    logic        pready0, pready1, pready, pslverr0, pslverr1, pslverr;
    logic        psel0, psel1;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem [2][16];

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [2:0]  p;
        bit          er;
        logic [31:0] rd;
    } vec_t;

    always #5 PCLK = ~PCLK;

    assign psel0   = psel && !which;
    assign psel1   = psel && which;
    assign prdata  = which ? prdata1 : prdata0;
    assign pready  = which ? pready1 : pready0;
    assign pslverr = which ? pslverr1 : pslverr0;

    apb4_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(0)) dut0 (
        .PCLK(PCLK), .PRESETn(rstn), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

    apb4_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(1)) dut1 (
        .PCLK(PCLK), .PRESETn(rstn), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++) mem[i][j] = '0;
    endtask

    // Reference: the transfer rules applied to a plain array
    task automatic model(input int wh, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p,
                         output logic [31:0] rd, output bit er);
        er = (a % 4 != 0) || (a >= 64) || (!w && s != 0) || (p[1] && a < 4);
        rd = '0;
        if (!er && !w) rd = mem[wh][a/4];
        if (!er && w)
            for (int b = 0; b < 4; b++)
                if (s[b]) mem[wh][a/4][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic xfer(input int wh, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p, input bit idle_after,
                        output logic [31:0] rd, output bit er, output int acc, output bit noisy);
        @(negedge PCLK);
        which = wh[0]; psel = 1; penable = 0; pwrite = w;
        paddr = a; pwdata = d; pstrb = s; pprot = p;
        @(negedge PCLK);
        penable = 1; acc = 1; noisy = 0;
        #1;
        while (!pready && acc < 40) begin
            if (pslverr || prdata != 0) noisy = 1;
            @(negedge PCLK); #1;
            acc++;
        end
        if (!pready) $display("FAIL timeout: no PREADY after %0d access cycles", acc);
        rd = prdata; er = pslverr;
        if (idle_after) begin
            @(negedge PCLK);
            psel = 0; penable = 0;
        end
    endtask

    task automatic run(input int wh, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p, input bit idle, input string tag,
                       output logic [31:0] rd, output bit er);
        int acc;
        bit noisy;
        logic [31:0] erd;
        bit eer;
        xfer(wh, w, a, d, s, p, idle, rd, er, acc, noisy);
        model(wh, w, a, d, s, p, erd, eer);
        chk({tag, " rdata"}, rd, erd);
        chk({tag, " pslverr"}, 32'(er), 32'(eer));
        chk({tag, " latency"}, acc, (wh != 0) ? 2 : 1);
        chk({tag, " quiet before ready"}, 32'(noisy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [22];
        logic [31:0] rd, a, d;
        logic [3:0] s;
        logic [2:0] p;
        bit er, w, hit;
        int wh, r;

        tbl[0]  = '{1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b000, 0, 32'h0};
        tbl[1]  = '{0, 32'h04, 32'h0,        4'h0, 3'b000, 0, 32'hDEADBEEF};
        tbl[2]  = '{1, 32'h08, 32'h11223344, 4'hF, 3'b000, 0, 32'h0};
        tbl[3]  = '{1, 32'h08, 32'hAABBCCDD, 4'h5, 3'b000, 0, 32'h0};
        tbl[4]  = '{0, 32'h08, 32'h0,        4'h0, 3'b000, 0, 32'h11BB33DD};
        tbl[5]  = '{1, 32'h00, 32'h12345678, 4'hF, 3'b000, 0, 32'h0};
        tbl[6]  = '{0, 32'h40, 32'h0,        4'h0, 3'b000, 1, 32'h0};
        tbl[7]  = '{0, 32'h06, 32'h0,        4'h0, 3'b000, 1, 32'h0};
        tbl[8]  = '{1, 32'h00, 32'hFFFFFFFF, 4'hF, 3'b010, 1, 32'h0};
        tbl[9]  = '{0, 32'h00, 32'h0,        4'h0, 3'b000, 0, 32'h12345678};
        tbl[10] = '{0, 32'h04, 32'h0,        4'h1, 3'b000, 1, 32'h0};
        tbl[11] = '{1, 32'h0C, 32'h00000055, 4'hF, 3'b000, 0, 32'h0};
        tbl[12] = '{1, 32'h0C, 32'hFFFFFFFF, 4'h0, 3'b000, 0, 32'h0};
        tbl[13] = '{0, 32'h0C, 32'h0,        4'h0, 3'b000, 0, 32'h00000055};
        tbl[14] = '{1, 32'h40, 32'hBAD0BAD0, 4'hF, 3'b000, 1, 32'h0};
        tbl[15] = '{0, 32'h00, 32'h0,        4'h0, 3'b000, 0, 32'h12345678};
        tbl[16] = '{1, 32'h3C, 32'hA5A5A5A5, 4'hC, 3'b000, 0, 32'h0};
        tbl[17] = '{0, 32'h3C, 32'h0,        4'h0, 3'b010, 0, 32'hA5A50000};
        tbl[18] = '{0, 32'h04, 32'h0,        4'h0, 3'b010, 0, 32'hDEADBEEF};
        tbl[19] = '{1, 32'h05, 32'h00000001, 4'hF, 3'b000, 1, 32'h0};
        tbl[20] = '{0, 32'h04, 32'h0,        4'h0, 3'b000, 0, 32'hDEADBEEF};
        tbl[21] = '{0, 32'h00, 32'h0,        4'h0, 3'b011, 1, 32'h0};

        rstn = 0; psel = 0; penable = 0; pwrite = 0;
        paddr = 0; pwdata = 0; pstrb = 0; pprot = 0; which = 1;
        model_reset();
        #1;
        chk("reset prdata w1", prdata1, 0);
        chk("reset pready w1", 32'(pready1), 0);
        chk("reset pslverr w1", 32'(pslverr1), 0);
        chk("reset prdata w0", prdata0, 0);
        chk("reset pready w0", 32'(pready0), 0);
        chk("reset pslverr w0", 32'(pslverr0), 0);
        repeat (3) @(negedge PCLK);
        rstn = 1;

        for (int i = 0; i < 22; i++) begin
            run(1, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].p, i[0], $sformatf("vec%0d", i), rd, er);
            chk($sformatf("vec%0d table rdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d table pslverr", i), 32'(er), 32'(tbl[i].er));
        end

        run(0, 1, 32'h0C, 32'hCAFEF00D, 4'hF, 3'b000, 0, "b2b wr", rd, er);
        run(0, 0, 32'h0C, 32'h0, 4'h0, 3'b000, 1, "b2b rd", rd, er);
        chk("b2b rd data", rd, 32'hCAFEF00D);

        for (int i = 0; i < 80; i++) begin
            wh = int'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            a  = (r < 7) ? 32'($urandom_range(0, 15)) * 4 :
                 (r == 7) ? 32'h40 + 32'($urandom_range(0, 15)) * 4 :
                 (r == 8) ? 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3)) : $urandom;
            d  = $urandom;
            s  = w ? 4'($urandom_range(0, 15)) : (($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
            p  = 3'($urandom_range(0, 7));
            run(wh, w, a, d, s, p, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), rd, er);
        end

        // reset while a read is presenting data: outputs drop without a clock edge
        @(negedge PCLK);
        which = 1; psel = 1; penable = 0; pwrite = 0; paddr = 32'h04; pstrb = 0; pprot = 0;
        @(negedge PCLK);
        penable = 1;
        @(negedge PCLK); #1;
        chk("pre-reset pready", 32'(pready), 1);
        chk("pre-reset prdata", prdata, mem[1][1]);
        rstn = 0; #1;
        chk("async reset pready", 32'(pready), 0);
        chk("async reset prdata", prdata, 0);
        chk("async reset pslverr", 32'(pslverr), 0);
        model_reset();
        @(negedge PCLK);
        psel = 0; penable = 0;
        @(negedge PCLK);
        rstn = 1;

        run(1, 1, 32'h10, 32'h00005A5A, 4'hF, 3'b000, 1, "pre wr 0x10", rd, er);
        @(negedge PCLK);
        which = 1; psel = 1; penable = 0; pwrite = 1; paddr = 32'h10; pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 0;
        @(negedge PCLK);
        penable = 1; #1;
        chk("wait cycle pready", 32'(pready), 0);
        #1 rstn = 0; #1;
        chk("mid-xfer reset pready", 32'(pready), 0);
        chk("mid-xfer reset prdata", prdata, 0);
        chk("mid-xfer reset pslverr", 32'(pslverr), 0);
        model_reset();
        @(negedge PCLK);
        psel = 0; penable = 0; rstn = 1;
        run(1, 0, 32'h10, 32'h0, 4'h0, 3'b000, 1, "post-reset rd 0x10", rd, er);
        chk("post-reset rd 0x10 zero", rd, 0);

        run(1, 1, 32'h14, 32'h00000077, 4'hF, 3'b000, 1, "pre-drop wr", rd, er);
        @(negedge PCLK);
        which = 1; psel = 1; penable = 0; pwrite = 1; paddr = 32'h14; pwdata = 32'h00000099; pstrb = 4'hF; pprot = 0;
        @(negedge PCLK);
        psel = 0; penable = 0; #1;
        chk("drop pready", 32'(pready), 0);
        @(negedge PCLK);
        psel = 1; penable = 1; hit = 0;
        repeat (4) begin
            @(negedge PCLK); #1;
            if (pready) hit = 1;
        end
        chk("enable without setup ignored", 32'(hit), 0);
        @(negedge PCLK);
        psel = 0; penable = 0;
        run(1, 0, 32'h14, 32'h0, 4'h0, 3'b000, 1, "post-drop rd", rd, er);
        chk("post-drop unchanged", rd, 32'h00000077);

        repeat (2) @(negedge PCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
